// File: rtl/line_drawer_gen_if.sv
// -----------------------------------------------------------------------------
// line_drawer_gen_if
// Command and pixel-stream bundle for the Bresenham line generator.
//   Command side : start/ready handshake, endpoints x0/y0/x1/y1 (signed),
//                  pacing interval, abort.
//   Pixel side   : x/y (signed) with pix_valid/pix_ready handshake.
//   Status       : busy, done.
// master = control logic driving commands and consuming pixels.
// slave  = the line generator.
// -----------------------------------------------------------------------------
interface line_drawer_gen_if #(
    parameter int CW   = 11,
    parameter int DIVW = 24
);
    logic                 start;
    logic                 ready;
    logic signed [CW-1:0] x0;
    logic signed [CW-1:0] y0;
    logic signed [CW-1:0] x1;
    logic signed [CW-1:0] y1;
    logic [DIVW-1:0]      interval;
    logic                 abort;
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 busy;
    logic                 done;

    modport master (
        output start, x0, y0, x1, y1, interval, abort, pix_ready,
        input  ready, x, y, pix_valid, busy, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, interval, abort, pix_ready,
        output ready, x, y, pix_valid, busy, done
    );
endinterface

// File: rtl/line_drawer_gen.sv
// -----------------------------------------------------------------------------
// line_drawer_gen
// Parametrised all-octant Bresenham line generator. A command carries both
// endpoints and a pacing interval; pixels stream out one per handshake with
// back-pressure, at least `interval` cycles apart, and the line can be aborted.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : line_drawer_gen_if.slave (command, pixel stream, status)
// -----------------------------------------------------------------------------
module line_drawer_gen #(
    parameter int CW   = 11,
    parameter int DIVW = 24
) (
    input  logic               clk,
    input  logic               reset,
    line_drawer_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [CW-1:0]   C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DIVW-1:0]        D_ONE  = {{(DIVW-1){1'b0}}, 1'b1};
    localparam logic signed [CW+1:0]   E_ZERO = '0;

    state_t               r_state;
    state_t               w_state_nxt;

    logic signed [CW-1:0] r_x;
    logic signed [CW-1:0] r_y;
    logic signed [CW-1:0] r_x1;
    logic signed [CW-1:0] r_y1;
    logic signed [CW:0]   r_dx;       // |x1-x0|
    logic signed [CW:0]   r_dy;       // -|y1-y0|
    logic signed [CW+1:0] r_err;
    logic                 r_sx_neg;   // step x by -1
    logic                 r_sy_neg;   // step y by -1
    logic [DIVW-1:0]      r_interval;
    logic [DIVW-1:0]      r_cnt;

    // Command-time arithmetic on the raw endpoint inputs
    logic signed [CW:0]   w_x0_ext, w_y0_ext, w_x1_ext, w_y1_ext;
    logic signed [CW:0]   w_ddx, w_ddy, w_dx_abs, w_dy_neg;
    logic signed [CW+1:0] w_dx_abs_e, w_dy_neg_e, w_err_init;
    logic [DIVW-1:0]      w_interval;

    // Per-pixel Bresenham step
    logic signed [CW+2:0] w_e2, w_dx_e3, w_dy_e3;
    logic signed [CW+1:0] w_dx_e2, w_dy_e2, w_err_step;
    logic                 w_step_x, w_step_y;

    logic w_accept, w_hs, w_last, w_wait_end, w_paced;

    assign w_x0_ext = bus.x0;
    assign w_y0_ext = bus.y0;
    assign w_x1_ext = bus.x1;
    assign w_y1_ext = bus.y1;
    assign w_ddx    = w_x1_ext - w_x0_ext;
    assign w_ddy    = w_y1_ext - w_y0_ext;
    assign w_dx_abs = w_ddx[CW] ? -w_ddx : w_ddx;
    assign w_dy_neg = w_ddy[CW] ? w_ddy : -w_ddy;
    assign w_dx_abs_e = w_dx_abs;
    assign w_dy_neg_e = w_dy_neg;
    assign w_err_init = w_dx_abs_e + w_dy_neg_e;
    // An interval of 0 paces exactly like 1
    assign w_interval = (bus.interval == '0) ? D_ONE : bus.interval;

    assign w_e2    = $signed({r_err, 1'b0});
    assign w_dx_e3 = r_dx;
    assign w_dy_e3 = r_dy;
    assign w_dx_e2 = r_dx;
    assign w_dy_e2 = r_dy;
    assign w_step_x = (w_e2 >= w_dy_e3);
    assign w_step_y = (w_e2 <= w_dx_e3);
    // Both terms apply on a diagonal step
    assign w_err_step = r_err + (w_step_x ? w_dy_e2 : E_ZERO)
                              + (w_step_y ? w_dx_e2 : E_ZERO);

    assign w_accept   = bus.start & (r_state == S_IDLE) & ~bus.abort;
    assign w_hs       = (r_state == S_EMIT) & bus.pix_ready;
    assign w_last     = (r_x == r_x1) && (r_y == r_y1);
    assign w_wait_end = (r_cnt == D_ONE);
    assign w_paced    = (r_interval > D_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else if (w_paced) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_wait_end) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort wins over everything outside IDLE
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_err      <= '0;
            r_sx_neg   <= 1'b0;
            r_sy_neg   <= 1'b0;
            r_interval <= D_ONE;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_x        <= bus.x0;
            r_y        <= bus.y0;
            r_x1       <= bus.x1;
            r_y1       <= bus.y1;
            r_dx       <= w_dx_abs;
            r_dy       <= w_dy_neg;
            r_err      <= w_err_init;
            r_sx_neg   <= !(bus.x0 < bus.x1);
            r_sy_neg   <= !(bus.y0 < bus.y1);
            r_interval <= w_interval;
        end else if (w_hs && !w_last && !bus.abort) begin
            if (w_step_x) begin
                r_x <= r_sx_neg ? (r_x - C_ONE) : (r_x + C_ONE);
            end
            if (w_step_y) begin
                r_y <= r_sy_neg ? (r_y - C_ONE) : (r_y + C_ONE);
            end
            r_err <= w_err_step;
            // The handshake cycle itself is the first of the interval
            r_cnt <= r_interval - D_ONE;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - D_ONE;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.pix_valid = (r_state == S_EMIT);
    assign bus.ready     = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_line_drawer_gen.sv
module tb_line_drawer_gen;
    localparam int CW   = 11;
    localparam int DIVW = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_drawer_gen_if #(.CW(CW), .DIVW(DIVW)) bus ();

    line_drawer_gen #(.CW(CW), .DIVW(DIVW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    int   hs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   done_base = 0;
    int   valid_cnt = 0;
    int   acc_cyc = 0;
    bit   prev_stall = 1'b0;
    int   px = 0;
    int   py = 0;
    pix_t e_pix;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int x, input int y);
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    // Scoreboard monitor: pops an expected pixel on every handshake
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                chk("hold_valid", bus.pix_valid, 1);
                chk("hold_x", bus.x, px);
                chk("hold_y", bus.y, py);
            end
            prev_stall = bus.pix_valid && !bus.pix_ready && !bus.abort;
            px = bus.x;
            py = bus.y;
            if (bus.pix_valid) valid_cnt++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: got (%0d,%0d) expected no pixel", bus.x, bus.y);
                end else begin
                    e_pix = exp_q.pop_front();
                    chk("pix_x", bus.x, e_pix.x);
                    chk("pix_y", bus.y, e_pix.y);
                end
                hs_q.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_line(input int x0, input int y0, input int x1, input int y1, input int intv);
        int n;
        n = 0;
        while (!bus.ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_start", bus.ready, 1);
        bus.x0 = CW'(x0);
        bus.y0 = CW'(y0);
        bus.x1 = CW'(x1);
        bus.y1 = CW'(y1);
        bus.interval = DIVW'(intv);
        bus.start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.start = 1'b0;
        hs_q.delete();
        valid_cnt = 0;
        done_base = done_cnt;
        // Junk inputs while busy must not disturb the line
        bus.x0 = CW'(123);
        bus.y0 = CW'(-77);
        bus.x1 = CW'(-300);
        bus.y1 = CW'(411);
        bus.interval = DIVW'(9);
        chk("busy_after_accept", bus.busy, 1);
    endtask

    task automatic finish_line(input int n_pix, input int pace);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt == done_base) chk("done_seen", 0, 1);
        chk("pix_count", hs_q.size(), n_pix);
        chk("queue_empty", exp_q.size(), 0);
        if (hs_q.size() > 0) begin
            chk("first_latency", hs_q[0], acc_cyc);
            chk("done_latency", done_cyc, hs_q[hs_q.size()-1] + 1);
        end
        if (pace > 0) begin
            for (int i = 1; i < hs_q.size(); i++) chk("pace", hs_q[i] - hs_q[i-1], pace);
            chk("valid_cycles", valid_cnt, n_pix);
        end
        @(negedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
        chk("ready_after_done", bus.ready, 1);
        chk("done_count", done_cnt, done_base + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pix_ready = 1'b1;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.x1 = '0;
        bus.y1 = '0;
        bus.interval = DIVW'(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Shallow octant, x dominant
        push(0,0); push(1,1); push(2,1); push(3,2); push(4,2);
        start_line(0, 0, 4, 2, 1);
        finish_line(5, 1);

        // Steep, x decreasing
        push(10,10); push(10,11); push(9,12); push(9,13); push(8,14); push(8,15);
        start_line(10, 10, 8, 15, 1);
        finish_line(6, 1);

        // Back-pressure on the second pixel for 3 cycles
        push(0,0); push(1,1); push(2,1); push(3,2); push(4,2);
        start_line(0, 0, 4, 2, 1);
        @(posedge clk); #1;
        chk("stall_x", bus.x, 1);
        chk("stall_y", bus.y, 1);
        chk("stall_valid", bus.pix_valid, 1);
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.pix_ready = 1'b1;
        finish_line(5, 0);

        // Paced at 5 cycles
        for (int i = 0; i <= 3; i++) push(i, 0);
        start_line(0, 0, 3, 0, 5);
        finish_line(4, 5);

        // Interval 0 paces as 1
        for (int i = 0; i <= 3; i++) push(i, 0);
        start_line(0, 0, 3, 0, 0);
        finish_line(4, 1);

        // Degenerate single pixel
        push(7, -3);
        start_line(7, -3, 7, -3, 1);
        finish_line(1, 1);

        // Horizontal through negative x
        for (int i = -5; i <= 5; i++) push(i, 0);
        start_line(-5, 0, 5, 0, 1);
        finish_line(11, 1);

        // start together with abort in IDLE is not accepted
        bus.x0 = CW'(0); bus.y0 = CW'(0); bus.x1 = CW'(3); bus.y1 = CW'(3);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_busy", bus.busy, 0);
        chk("abort_start_ready", bus.ready, 1);

        // Abort while the third pixel is presented
        push(0,0); push(1,1); push(2,2);
        start_line(0, 0, 20, 20, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pix_x", bus.x, 2);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_valid", bus.pix_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (5) begin
            @(negedge clk); #1;
        end
        chk("abort_no_done", done_cnt, done_base);
        chk("abort_queue", exp_q.size(), 0);
        chk("abort_pix_count", hs_q.size(), 3);

        // Recovery line, both steps negative
        push(0,0); push(-1,-1); push(-2,-1);
        start_line(0, 0, -2, -1, 1);
        finish_line(3, 1);

        // Asynchronous reset mid-line
        for (int i = 0; i <= 20; i++) push(i, i);
        start_line(0, 0, 20, 20, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", bus.pix_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.ready, 1);
        chk("arst_done", bus.done, 0);
        chk("arst_x", bus.x, 0);
        chk("arst_y", bus.y, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_done", done_cnt, done_base);

        push(0,0); push(1,1); push(2,1); push(3,2); push(4,2);
        start_line(0, 0, 4, 2, 1);
        finish_line(5, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
